apb_master_arb: RTL and testbench

- Two-requester APB master. Round-robin arbitration, then a single APB transfer to one of NSLV register slaves (apb_regs instances), selected by decoding paddr[31:AW].
- Replaces testbench-driven APB sequencing in the register subsystem.
- Sits between on-chip control agents (CPU bridge, debug port) and the shared APB segment.

---
 rtl/apb_arb_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 18 +
 rtl/apb_master_arb.sv | 190 +++++++++++++++++++
 tb/tb_apb_master_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and helpers for the two-requester APB master.
// Provides the FSM state enum, direction constants and slave-index decode.
package apb_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACCESS,
      DECERR,
      RESP
   } state_t;

   localparam logic WRITE = 1'b1;
   localparam logic READ  = 1'b0;

   // Slave index is the address bits above the slave-local window.
   function automatic logic [31:0] slv_index(
      input logic [31:0] addr,
      input int          aw
   );
      return addr >> aw;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter.
// Ports: req[1:0], ptr (preferred requester) -> grant (one-hot), idx.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] grant,
   output logic       idx
);

   always_comb begin
      grant = 2'b00;
      idx   = req[ptr] ? ptr : ~ptr;
      if (req != 2'b00) begin
         grant[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb: two-requester round-robin APB master, NSLV slaves.
// Ports: pclk, presetn (async, active-high); req_* request side in,
// req_ack/rsp_* out; paddr/pwrite/pwdata/psel/penable APB out;
// prdata/pready/pslverr per-slave in.
// Optional macro APB_TIMEOUT_EN: abort ACCESS after TIMEOUT cycles.
module apb_master_arb
   import apb_arb_pkg::*;
#(
   parameter int AW      = 5,
   parameter int DW      = 32,
   parameter int NSLV    = 2,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic [1:0]        req_valid,
   input  logic [1:0]        req_write,
   input  logic [63:0]       req_addr,
   input  logic [2*DW-1:0]   req_wdata,
   output logic [1:0]        req_ack,
   output logic [1:0]        rsp_valid,
   output logic [DW-1:0]     rsp_rdata,
   output logic              rsp_err,
   output logic [31:0]       paddr,
   output logic              pwrite,
   output logic [DW-1:0]     pwdata,
   output logic [NSLV-1:0]   psel,
   output logic              penable,
   input  logic [NSLV*DW-1:0] prdata,
   input  logic [NSLV-1:0]   pready,
   input  logic [NSLV-1:0]   pslverr
);

   localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

   state_t          state_q;
   state_t          state_d;
   logic            ptr_q;
   logic            gidx_q;
   logic [IW-1:0]   sidx_q;
   logic [31:0]     addr_q;
   logic [DW-1:0]   wdata_q;
   logic            wr_q;
   logic [DW-1:0]   rdata_q;
   logic            err_q;

   logic [1:0]      grant;
   logic            gidx;
   logic [31:0]     addr_g;
   logic [31:0]     sdec;
   logic            in_range;
   logic [DW-1:0]   prd_sel;
   logic            rdy_sel;
   logic            err_sel;
   logic            expire;

   rr_arb2 u_arb (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (gidx)
   );

   assign addr_g   = gidx ? req_addr[63:32] : req_addr[31:0];
   assign sdec     = slv_index(addr_g, AW);
   assign in_range = sdec < 32'(NSLV);

   // Mux the addressed slave's response; other slaves are ignored.
   always_comb begin
      prd_sel = '0;
      rdy_sel = 1'b0;
      err_sel = 1'b0;
      for (int i = 0; i < NSLV; i++) begin
         if (IW'(i) == sidx_q) begin
            prd_sel = prdata[i*DW +: DW];
            rdy_sel = pready[i];
            err_sel = pslverr[i];
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q;

   always_ff @(posedge pclk or posedge presetn) begin
      if (presetn) begin
         cnt_q <= '0;
      end else if (state_q == SETUP) begin
         cnt_q <= '0;
      end else if (state_q == ACCESS) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // A late pready in the last allowed cycle still completes normally.
   assign expire = (state_q == ACCESS) && !rdy_sel &&
                   (cnt_q == CW'(TIMEOUT - 1));
`else
   localparam int unused_timeout = TIMEOUT;
   assign expire = 1'b0;
`endif

   always_ff @(posedge pclk or posedge presetn) begin
      if (presetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               state_d = in_range ? SETUP : DECERR;
            end
         end
         SETUP:  state_d = ACCESS;
         ACCESS: begin
            if (rdy_sel || expire) begin
               state_d = RESP;
            end
         end
         DECERR: state_d = RESP;
         RESP:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge presetn) begin
      if (presetn) begin
         ptr_q   <= 1'b0;
         gidx_q  <= 1'b0;
         sidx_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state_q == IDLE && grant != 2'b00) begin
            ptr_q   <= ~gidx;
            gidx_q  <= gidx;
            sidx_q  <= IW'(sdec);
            addr_q  <= addr_g;
            wdata_q <= req_wdata[gidx*DW +: DW];
            wr_q    <= req_write[gidx];
         end
         if (state_q == ACCESS && rdy_sel) begin
            rdata_q <= (wr_q == READ) ? prd_sel : '0;
            err_q   <= err_sel;
         end
         if (state_q == DECERR || expire) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
      end
   end

   always_comb begin
      req_ack   = 2'b00;
      rsp_valid = 2'b00;
      psel      = '0;
      penable   = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Gated so no ack leaks out while reset is held.
            if (!presetn) begin
               req_ack = grant;
            end
         end
         SETUP: psel[sidx_q] = 1'b1;
         ACCESS: begin
            psel[sidx_q] = 1'b1;
            penable      = 1'b1;
         end
         RESP: rsp_valid[gidx_q] = 1'b1;
         default: ;
      endcase
   end

   assign paddr     = addr_q;
   assign pwrite    = wr_q;
   assign pwdata    = wdata_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: directed self-checking bench for apb_master_arb.
// Two behavioural register slaves sit on the APB side.
module tb_apb_master_arb;
   import apb_arb_pkg::*;

   logic        pclk = 1'b0;
   logic        presetn;
   logic [1:0]  req_valid;
   logic [1:0]  req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_ack;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [1:0]  psel;
   logic        penable;
   logic [63:0] prdata;
   logic [1:0]  pready;
   logic [1:0]  pslverr;

   logic [31:0] mem [2][8];
   logic [1:0]  rdy;
   logic [1:0]  serr;

   int nerr = 0;
   int nchk = 0;

   always #5 pclk = ~pclk;

   apb_master_arb #(
      .AW(5), .DW(32), .NSLV(2), .TIMEOUT(4)
   ) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ack   (req_ack),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .paddr     (paddr),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .psel      (psel),
      .penable   (penable),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   assign pready  = rdy;
   assign pslverr = serr;

   always_comb begin
      prdata = {mem[1][paddr[4:2]], mem[0][paddr[4:2]]};
   end

   always @(posedge pclk) begin
      if (presetn) begin
         for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 8; w++) begin
               mem[s][w] <= 32'h0;
            end
         end
         mem[0][0] <= 32'h0A0A0000;
         mem[1][0] <= 32'h1B1B0000;
         mem[1][1] <= 32'h32132132;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (psel[s] && penable && pready[s] && pwrite) begin
               mem[s][paddr[4:2]] <= pwdata;
            end
         end
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge pclk);
      #1;
   endtask

   initial begin
      presetn   = 1'b1;
      req_valid = 2'b11;
      req_write = 2'b00;
      req_addr  = '0;
      req_wdata = '0;
      rdy       = 2'b11;
      serr      = 2'b00;
      tick();
      tick();
      chk("rst ack", 32'(req_ack), 32'h0);
      chk("rst psel", 32'(psel), 32'h0);
      chk("rst penable", 32'(penable), 32'h0);
      chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst paddr", paddr, 32'h0);
      chk("rst rdata", rsp_rdata, 32'h0);
      chk("rst err", 32'(rsp_err), 32'h0);
      req_valid = 2'b00;
      presetn   = 1'b0;
      tick();

      // Requester 0 write, slave 0, zero wait states.
      req_valid       = 2'b01;
      req_write       = {1'b0, WRITE};
      req_addr[31:0]  = 32'h04;
      req_wdata[31:0] = 32'hFFFFFF04;
      #1;
      chk("t1 ack", 32'(req_ack), 32'h1);
      tick();
      req_valid = 2'b00;
      chk("t1 setup psel", 32'(psel), 32'h1);
      chk("t1 setup penable", 32'(penable), 32'h0);
      chk("t1 paddr", paddr, 32'h04);
      chk("t1 pwrite", 32'(pwrite), 32'h1);
      chk("t1 pwdata", pwdata, 32'hFFFFFF04);
      tick();
      chk("t1 access psel", 32'(psel), 32'h1);
      chk("t1 access penable", 32'(penable), 32'h1);
      tick();
      chk("t1 rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1 rsp_err", 32'(rsp_err), 32'h0);
      chk("t1 resp psel", 32'(psel), 32'h0);
      tick();
      chk("t1 idle rsp_valid", 32'(rsp_valid), 32'h0);
      chk("t1 slave0 reg", mem[0][1], 32'hFFFFFF04);

      // Requester 1 read, slave 1.
      req_valid       = 2'b10;
      req_write       = 2'b00;
      req_addr[63:32] = 32'h24;
      #1;
      chk("t2 ack", 32'(req_ack), 32'h2);
      tick();
      req_valid = 2'b00;
      chk("t2 psel", 32'(psel), 32'h2);
      chk("t2 paddr", paddr, 32'h24);
      chk("t2 pwrite", 32'(pwrite), 32'h0);
      tick();
      chk("t2 penable", 32'(penable), 32'h1);
      tick();
      chk("t2 rsp_valid", 32'(rsp_valid), 32'h2);
      chk("t2 rdata", rsp_rdata, 32'h32132132);
      chk("t2 err", 32'(rsp_err), 32'h0);
      tick();

      // Both requesters held valid: strict alternation from 0.
      req_addr  = {32'h20, 32'h00};
      req_valid = 2'b11;
      #1;
      for (int t = 0; t < 4; t++) begin
         chk($sformatf("t3 ack %0d", t), 32'(req_ack), 32'(1 << (t & 1)));
         tick();
         chk($sformatf("t3 ack off %0d", t), 32'(req_ack), 32'h0);
         chk($sformatf("t3 psel %0d", t), 32'(psel), 32'(1 << (t & 1)));
         tick();
         tick();
         chk($sformatf("t3 rsp_valid %0d", t), 32'(rsp_valid),
             32'(1 << (t & 1)));
         chk($sformatf("t3 rdata %0d", t), rsp_rdata,
             (t & 1) ? 32'h1B1B0000 : 32'h0A0A0000);
         tick();
      end
      req_valid = 2'b00;

      // Out-of-range slave index: IDLE, DECERR, RESP.
      req_valid      = 2'b01;
      req_addr[31:0] = 32'h40;
      #1;
      chk("t4 ack", 32'(req_ack), 32'h1);
      tick();
      req_valid = 2'b00;
      chk("t4 psel", 32'(psel), 32'h0);
      chk("t4 penable", 32'(penable), 32'h0);
      tick();
      chk("t4 rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t4 err", 32'(rsp_err), 32'h1);
      chk("t4 rdata", rsp_rdata, 32'h0);
      chk("t4 resp psel", 32'(psel), 32'h0);
      tick();
      chk("t4 idle rsp_valid", 32'(rsp_valid), 32'h0);

      // Wait states then slave error; pready lands on 4th ACCESS.
      rdy[1]           = 1'b0;
      req_valid        = 2'b10;
      req_write        = 2'b10;
      req_addr[63:32]  = 32'h28;
      req_wdata[63:32] = 32'h55AA55AA;
      #1;
      chk("t5 ack", 32'(req_ack), 32'h2);
      tick();
      req_valid = 2'b00;
      tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("t5 wait psel %0d", k), 32'(psel), 32'h2);
         chk($sformatf("t5 wait penable %0d", k), 32'(penable), 32'h1);
         tick();
      end
      rdy[1]  = 1'b1;
      serr[1] = 1'b1;
      chk("t5 last psel", 32'(psel), 32'h2);
      chk("t5 last rsp_valid", 32'(rsp_valid), 32'h0);
      tick();
      chk("t5 rsp_valid", 32'(rsp_valid), 32'h2);
      chk("t5 err", 32'(rsp_err), 32'h1);
      chk("t5 rdata", rsp_rdata, 32'h0);
      rdy  = 2'b11;
      serr = 2'b00;
      req_write = 2'b00;
      tick();

`ifdef APB_TIMEOUT_EN
      // pready stuck low: abort after 4 ACCESS cycles.
      rdy[0]         = 1'b0;
      req_valid      = 2'b01;
      req_addr[31:0] = 32'h00;
      #1;
      chk("t6 ack", 32'(req_ack), 32'h1);
      tick();
      req_valid = 2'b00;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t6 penable %0d", k), 32'(penable), 32'h1);
         chk($sformatf("t6 rsp_valid %0d", k), 32'(rsp_valid), 32'h0);
         tick();
      end
      chk("t6 rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t6 err", 32'(rsp_err), 32'h1);
      chk("t6 rdata", rsp_rdata, 32'h0);
      chk("t6 psel", 32'(psel), 32'h0);
      rdy = 2'b11;
      tick();
`endif

      // Reset during ACCESS drops the transfer, pointer back to 0.
      rdy[0]         = 1'b0;
      req_valid      = 2'b01;
      req_addr[31:0] = 32'h00;
      #1;
      chk("t7 ack", 32'(req_ack), 32'h1);
      tick();
      req_valid = 2'b00;
      tick();
      chk("t7 access penable", 32'(penable), 32'h1);
      presetn = 1'b1;
      #1;
      chk("t7 rst psel", 32'(psel), 32'h0);
      chk("t7 rst penable", 32'(penable), 32'h0);
      chk("t7 rst rsp_valid", 32'(rsp_valid), 32'h0);
      tick();
      tick();
      chk("t7 rst hold rsp_valid", 32'(rsp_valid), 32'h0);
      rdy       = 2'b11;
      req_valid = 2'b11;
      req_addr  = {32'h20, 32'h00};
      presetn   = 1'b0;
      #1;
      chk("t7 post ack", 32'(req_ack), 32'h1);
      tick();
      req_valid = 2'b00;
      chk("t7 post psel", 32'(psel), 32'h1);
      tick();
      tick();
      chk("t7 post rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t7 post rdata", rsp_rdata, 32'h0A0A0000);
      tick();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
